// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button debouncer.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  function automatic longint ms_to_cycles(input longint osc_f, input longint ms);
    return (osc_f / 1000) * ms;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous 1-bit board input.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/button_debounce.sv
// Debounces the active-low board button into a level plus press/release/long strobes.
// Define BUTTON_REPEAT_EN to re-fire press_pulse periodically after a long press.
module button_debounce
  import btn_pkg::*;
#(
  parameter int OscF        = 24_000_000,
  parameter int DebounceMs  = 20,
  parameter int LongPressMs = 1000,
  parameter int RepeatMs    = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam longint DEB_L  = ms_to_cycles(OscF, DebounceMs);
  localparam longint LONG_L = ms_to_cycles(OscF, LongPressMs);
  localparam longint REP_L  = ms_to_cycles(OscF, RepeatMs);
  localparam longint MAX_DL = (DEB_L > LONG_L) ? DEB_L : LONG_L;
  localparam longint MAX_L  = (MAX_DL > REP_L) ? MAX_DL : REP_L;
  localparam int     CW     = $clog2(MAX_L) + 1;

  localparam logic [CW-1:0] DEB_M2  = (DEB_L >= 2) ? CW'(DEB_L - 2) : '0;
  localparam logic [CW-1:0] LONG_C  = CW'(LONG_L);
  localparam logic [CW-1:0] LONG_M1 = (LONG_L >= 1) ? CW'(LONG_L - 1) : '0;
  localparam bit            DEB_ONE = (DEB_L == 1);

  if (DEB_L < 1) begin : g_bad_deb
    $error("button_debounce: DebCycles must be at least 1");
  end

  logic sync_n, sync_p;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (button),
    .q     (sync_n)
  );

  assign sync_p = ~sync_n;

  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, hold_cnt_q, hold_cnt_d, hold_inc;
  logic          pressed_q, pressed_d, press_q, press_d;
  logic          release_q, release_d, long_q, long_d;
`ifdef BUTTON_REPEAT_EN
  localparam logic [CW-1:0] REP_C = CW'(REP_L);
  logic [CW-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
`endif

  assign hold_inc = (hold_cnt_q == LONG_C) ? LONG_C : hold_cnt_q + CW'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_cnt_d = hold_cnt_q;
    pressed_d  = pressed_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
`ifdef BUTTON_REPEAT_EN
    rep_cnt_d  = rep_cnt_q;
    rep_inc    = rep_cnt_q + CW'(1);
`endif
    unique case (state_q)
      RELEASED: begin
        hold_cnt_d = '0;
`ifdef BUTTON_REPEAT_EN
        rep_cnt_d  = '0;
`endif
        if (sync_p) begin
          cnt_d = '0;
          if (DEB_ONE) begin
            state_d   = HELD;
            press_d   = 1'b1;
            pressed_d = 1'b1;
          end else begin
            state_d = PRESS_WAIT;
          end
        end
      end
      PRESS_WAIT: begin
        if (!sync_p) begin
          state_d = RELEASED;
        end else if (cnt_q == DEB_M2) begin
          state_d    = HELD;
          press_d    = 1'b1;
          pressed_d  = 1'b1;
          hold_cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        hold_cnt_d = hold_inc;
        // hold_inc only passes LONG_M1 once per press, so this fires once
        if (hold_inc == LONG_M1 && hold_cnt_q != LONG_M1) begin
          long_d = 1'b1;
`ifdef BUTTON_REPEAT_EN
          rep_cnt_d = '0;
        end else if (hold_cnt_q >= LONG_M1) begin
          // repeat timer runs only while firmly held; a release bounce freezes it
          if (rep_inc == REP_C) begin
            press_d   = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_inc;
          end
`endif
        end
        if (!sync_p) begin
          cnt_d = '0;
          if (DEB_ONE) begin
            state_d    = RELEASED;
            release_d  = 1'b1;
            pressed_d  = 1'b0;
            hold_cnt_d = '0;
`ifdef BUTTON_REPEAT_EN
            press_d    = 1'b0;
`endif
          end else begin
            state_d = RELEASE_WAIT;
          end
        end
      end
      RELEASE_WAIT: begin
        hold_cnt_d = hold_inc;
        if (sync_p) begin
          state_d = HELD;
        end else if (cnt_q == DEB_M2) begin
          state_d    = RELEASED;
          release_d  = 1'b1;
          pressed_d  = 1'b0;
          hold_cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RELEASED;
      cnt_q      <= '0;
      hold_cnt_q <= '0;
      pressed_q  <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
`ifdef BUTTON_REPEAT_EN
      rep_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_cnt_q <= hold_cnt_d;
      pressed_q  <= pressed_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
`ifdef BUTTON_REPEAT_EN
      rep_cnt_q  <= rep_cnt_d;
`endif
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: DebCycles=20, LongCycles=100, RepCycles=50.
module tb_button_debounce;

  logic clk = 1'b0;
  logic rst_n, button;
  logic pressed, press_pulse, release_pulse, long_pulse;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int multi_strobe = 0;
  int press_q[$], release_q[$], long_q[$];

  button_debounce #(
    .OscF(10_000), .DebounceMs(2), .LongPressMs(10), .RepeatMs(5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .button        (button),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // cyc at a negedge equals the number of rising edges seen so far
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (press_pulse === 1'b1)   press_q.push_back(cyc);
      if (release_pulse === 1'b1) release_q.push_back(cyc);
      if (long_pulse === 1'b1)    long_q.push_back(cyc);
      if (int'(press_pulse === 1'b1) + int'(release_pulse === 1'b1) + int'(long_pulse === 1'b1) > 1)
        multi_strobe++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_q();
    press_q.delete(); release_q.delete(); long_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; button = 1'b1;
    step(3);
    total_cnt++;
    if ({pressed, press_pulse, release_pulse, long_pulse} !== 4'b0000)
      $display("FAIL reset_outputs got %b exp 0000", {pressed, press_pulse, release_pulse, long_pulse});
    else pass_cnt++;
    rst_n = 1'b1;
    step(30);
    total_cnt++;
    if (press_q.size() != 0 || pressed !== 1'b0)
      $display("FAIL reset_idle got presses=%0d pressed=%b exp 0 0", press_q.size(), pressed);
    else pass_cnt++;
  endtask

  task automatic test_clean_press();
    int t0, t1;
    int exp_np;
    clear_q();
    t0 = cyc; button = 1'b0;
    step(21);
    total_cnt++;
    if (pressed !== 1'b0) $display("FAIL clean_pressed_early got %b exp 0", pressed);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (pressed !== 1'b1 || press_pulse !== 1'b1)
      $display("FAIL clean_pressed_at22 got pressed=%b pulse=%b exp 1 1", pressed, press_pulse);
    else pass_cnt++;
    step(178);
    t1 = cyc; button = 1'b1;
    step(40);
`ifdef BUTTON_REPEAT_EN
    exp_np = 2;
`else
    exp_np = 1;
`endif
    total_cnt++;
    if (press_q.size() != exp_np || press_q[0] != t0 + 22)
      $display("FAIL clean_press_pulse got n=%0d first=%0d exp n=%0d at %0d", press_q.size(), press_q[0] - t0, exp_np, 22);
    else pass_cnt++;
    total_cnt++;
    if (long_q.size() != 1 || long_q[0] != t0 + 121)
      $display("FAIL clean_long got n=%0d at=%0d exp n=1 at 121", long_q.size(), long_q[0] - t0);
    else pass_cnt++;
    total_cnt++;
    if (release_q.size() != 1 || release_q[0] != t1 + 22 || pressed !== 1'b0)
      $display("FAIL clean_release got n=%0d at=%0d pressed=%b exp n=1 at 22 pressed=0", release_q.size(), release_q[0] - t1, pressed);
    else pass_cnt++;
  endtask

  task automatic test_bounce();
    int t0, tl;
    clear_q();
    t0 = cyc;
    for (int i = 0; i < 12; i++) begin
      button = i[0];
      step(5);
    end
    tl = cyc; button = 1'b0;
    step(40);
    total_cnt++;
    if (press_q.size() != 1 || press_q[0] != tl + 22)
      $display("FAIL bounce_press got n=%0d at=%0d exp n=1 at 22", press_q.size(), press_q[0] - tl);
    else pass_cnt++;
    total_cnt++;
    if (release_q.size() != 0 || pressed !== 1'b1)
      $display("FAIL bounce_no_release got n=%0d pressed=%b exp 0 1 (start %0d)", release_q.size(), pressed, t0);
    else pass_cnt++;
    button = 1'b1;
    step(30);
  endtask

  task automatic test_glitch();
    int seen_pressed;
    clear_q();
    seen_pressed = 0;
    button = 1'b0;
    for (int i = 0; i < 10; i++) begin step(1); if (pressed !== 1'b0) seen_pressed++; end
    button = 1'b1;
    for (int i = 0; i < 40; i++) begin step(1); if (pressed !== 1'b0) seen_pressed++; end
    total_cnt++;
    if (press_q.size() + release_q.size() + long_q.size() != 0 || seen_pressed != 0)
      $display("FAIL glitch got strobes=%0d pressed_cycles=%0d exp 0 0", press_q.size() + release_q.size() + long_q.size(), seen_pressed);
    else pass_cnt++;
  endtask

  task automatic test_short_press();
    int t0, t1;
    clear_q();
    t0 = cyc; button = 1'b0;
    step(50);
    t1 = cyc; button = 1'b1;
    step(40);
    total_cnt++;
    if (press_q.size() != 1 || press_q[0] != t0 + 22 || release_q.size() != 1 || release_q[0] != t1 + 22)
      $display("FAIL short_press got press n=%0d rel n=%0d rel_at=%0d exp 1 1 22", press_q.size(), release_q.size(), release_q[0] - t1);
    else pass_cnt++;
    total_cnt++;
    if (long_q.size() != 0) $display("FAIL short_no_long got n=%0d exp 0", long_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_hold();
    int tr;
    button = 1'b0;
    step(30);
    clear_q();
    rst_n = 1'b0;
    step(3);
    total_cnt++;
    if ({pressed, press_pulse, release_pulse, long_pulse} !== 4'b0000)
      $display("FAIL midreset_outputs got %b exp 0000", {pressed, press_pulse, release_pulse, long_pulse});
    else pass_cnt++;
    tr = cyc; rst_n = 1'b1;
    step(30);
    total_cnt++;
    if (press_q.size() != 1 || press_q[0] != tr + 22)
      $display("FAIL midreset_repress got n=%0d at=%0d exp n=1 at 22", press_q.size(), press_q[0] - tr);
    else pass_cnt++;
    total_cnt++;
    if (release_q.size() != 0) $display("FAIL midreset_no_release got n=%0d exp 0", release_q.size());
    else pass_cnt++;
    button = 1'b1;
    step(30);
  endtask

  task automatic test_repeat();
    int t0;
    int exp_at[$];
    clear_q();
`ifdef BUTTON_REPEAT_EN
    exp_at = '{22, 171, 221, 271};
`else
    exp_at = '{22};
`endif
    t0 = cyc; button = 1'b0;
    step(300);
    button = 1'b1;
    step(30);
    total_cnt++;
    if (press_q.size() != exp_at.size())
      $display("FAIL repeat_count got %0d exp %0d", press_q.size(), exp_at.size());
    else pass_cnt++;
    for (int i = 0; i < exp_at.size() && i < press_q.size(); i++) begin
      total_cnt++;
      if (press_q[i] != t0 + exp_at[i])
        $display("FAIL repeat_at[%0d] got %0d exp %0d", i, press_q[i] - t0, exp_at[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (long_q.size() != 1 || long_q[0] != t0 + 121)
      $display("FAIL repeat_long got n=%0d at=%0d exp n=1 at 121", long_q.size(), long_q[0] - t0);
    else pass_cnt++;
  endtask

  task automatic test_strobe_exclusive();
    total_cnt++;
    if (multi_strobe != 0) $display("FAIL strobe_exclusive got %0d overlaps exp 0", multi_strobe);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_short_press();
    test_reset_mid_hold();
    test_repeat();
    test_strobe_exclusive();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Input-side companion to the board's LED/oscillator test logic: samples the raw active-low push-button and produces clean, debounced events.
- Synchronises the asynchronous pin, filters bounce with a stable-time counter, and reports press, release and long-press.
- Sits between the board `button` pin and any test or control logic that needs one clean event per physical press.

Parameters:
- OscF, 24_000_000, clk frequency in Hz.
- DebounceMs, 20, time in ms the input must stay stable before a level change is accepted.
- LongPressMs, 1000, time in ms held (after debounce) before long_pulse fires.
- RepeatMs, 200, auto-repeat period in ms (used only with BUTTON_REPEAT_EN).

Ports:
- clk  in  1  system clock, OscF Hz.
- rst_n  in  1  synchronous reset, active-low.
- button  in  1  raw pin, active-low (0 = pressed), asynchronous to clk.
- pressed  out  1  debounced level, active-high.
- press_pulse  out  1  one-cycle strobe on accepted press.
- release_pulse  out  1  one-cycle strobe on accepted release.
- long_pulse  out  1  one-cycle strobe when hold reaches LongPressMs.

Behaviour:
- Derived constants, computed with 64-bit intermediate arithmetic:
  - DebCycles = OscF/1000*DebounceMs.
  - LongCycles = OscF/1000*LongPressMs.
  - RepCycles = OscF/1000*RepeatMs.
  - Counter width = $clog2(max of the three)+1.
- Reset, sampled on clk rising edge while rst_n=0:
  - Both synchroniser flops = 1 (released).
  - State = RELEASED, counters = 0.
  - All outputs = 0.
- Synchroniser: 2 flops; sync_n = second flop. Invert to get sync_p (1 = pressed).
- FSM states:
  - RELEASED: if sync_p=1, go to PRESS_WAIT and set cnt=0.
  - PRESS_WAIT:
    - sync_p=0 → back to RELEASED. This is a glitch; no event.
    - Otherwise cnt++. At cnt==DebCycles-1 → HELD, press_pulse=1 for that cycle, pressed=1.
  - HELD:
    - hold_cnt increments every cycle, saturating at LongCycles.
    - hold_cnt reaching LongCycles-1 → long_pulse=1 for exactly one cycle. Once per press.
    - sync_p=0 → RELEASE_WAIT, cnt=0. hold_cnt is retained.
  - RELEASE_WAIT:
    - sync_p=1 → back to HELD. Bounce; no event; hold_cnt keeps counting.
    - At cnt==DebCycles-1 → RELEASED, release_pulse=1, pressed=0, hold_cnt=0.
- Latency: pin edge to press_pulse = 2 (sync) + DebCycles cycles.
- pressed changes in the same cycle its strobe is asserted. Strobes are registered outputs.
- At most one strobe is high per cycle. If long and release would coincide, the long threshold is evaluated only in HELD, so they cannot overlap.
- Button held low through reset: a press is reported 2+DebCycles cycles after rst_n rises.
- rst_n asserted mid-operation: immediate return to the reset state on the next edge; no release_pulse is emitted.
- DebCycles < 1 is illegal; elaboration fails via a generate-time check.

Optional Feature:
- Macro: BUTTON_REPEAT_EN.
- Defined:
  - After long_pulse, while still in HELD or RELEASE_WAIT-bounce, press_pulse re-fires every RepCycles cycles. The first repeat comes RepCycles cycles after long_pulse.
  - rep_cnt clears on leaving HELD to RELEASED.
- Undefined: press_pulse fires exactly once per press; rep_cnt logic is absent.

Decomposition:
- Package btn_pkg:
  - FSM state enum: RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT, 2-bit.
  - ms_to_cycles(OscF, ms) constant function.
- Sub-module sync_2ff (parameterised reset value, 1-bit) for the pin synchroniser. It is reused for any other board input.

Test Plan (OscF=10_000, DebounceMs=2 → DebCycles=20, LongPressMs=10 → LongCycles=100, RepeatMs=5 → RepCycles=50):
- Clean press: button 1→0 held 200 cycles → press_pulse at edge+22, pressed=1; long_pulse at edge+22+100-1 once; release 22 cycles after button→1.
- Bounce: button toggles every 5 cycles for 60 cycles, then stays 0 → exactly one press_pulse, 22 cycles after the last transition; no release_pulse.
- Glitch: button low for 10 cycles only → no strobes; pressed stays 0.
- Short press: held 50 cycles → press_pulse and release_pulse, no long_pulse.
- Reset mid-hold: rst_n=0 for 3 cycles while pressed=1 → all outputs 0, no release_pulse; button still low → new press_pulse 22 cycles after rst_n rises.
- BUTTON_REPEAT_EN: held 300 cycles → press_pulse at 22, long at 121, repeats at 171, 221, 271; without the macro, only the pulse at 22.
